// File: rtl/eight_bit_comp_ctrl.sv
// eight_bit_comp_ctrl
// Collects two 8-bit operands one nibble at a time from four push-buttons
// and the Y switches. Once all four nibbles are present it waits one cycle
// for the external comparator to settle, then registers its result.
// A press after a result starts a new round: the pressed nibble is reloaded
// and the other three keep their previous values.

module eight_bit_comp_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       PB1,
   input  logic       PB2,
   input  logic       PB3,
   input  logic       PB4,
   input  logic [3:0] Y,
   input  logic       cmp_l,
   input  logic       cmp_g,
   input  logic       cmp_eq,
   output logic [7:0] a_op,
   output logic [7:0] b_op,
   output logic [3:0] loaded,
   output logic       l,
   output logic       g,
   output logic       eq,
   output logic       valid,
   output logic       err
);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } ctrlState_t;

   ctrlState_t                  state;

   logic [3:0]                  pbRaw;
   logic [3:0][SYNC_STAGES-1:0] syncChain;
   logic [3:0]                  syncLevel;
   logic [3:0]                  prevLevel;
   logic [3:0]                  armed;
   logic [SYNC_STAGES-1:0]      primeSr;
   logic [3:0]                  pulse;
   logic [3:0]                  loadEn;
   logic [2:0]                  cmpVec;
   logic                        cmpOneHot;

   assign pbRaw  = {PB4, PB3, PB2, PB1};
   assign cmpVec = {cmp_l, cmp_g, cmp_eq};

   // Bring each raw button into the clock domain and remember the previous
   // synchronized level for edge detection. A button only becomes "armed"
   // once its synchronized level has been seen low after the chain has been
   // refilled following reset; primeSr marks when that chain is trustworthy.
   // This keeps a button held through reset release from looking like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         syncChain <= '0;
         prevLevel <= '0;
         armed     <= '0;
         primeSr   <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            syncChain[i] <= {syncChain[i][SYNC_STAGES-2:0], pbRaw[i]};
         end
         prevLevel <= syncLevel;
         primeSr   <= {primeSr[SYNC_STAGES-2:0], 1'b1};
         armed     <= armed | (~syncLevel & {4{primeSr[SYNC_STAGES-1]}});
      end
   end

   // Take the last synchronizer stage, turn rising edges into one-cycle
   // pulses, block loads while the comparator is settling and judge whether
   // the comparator result is a clean one-hot code.
   always_comb begin
      syncLevel = '0;
      for (int i = 0; i < 4; i++) begin
         syncLevel[i] = syncChain[i][SYNC_STAGES-1];
      end
      pulse     = syncLevel & ~prevLevel & armed;
      loadEn    = (state == SETTLE) ? 4'b0000 : pulse;
      cmpOneHot = (cmpVec == 3'b100) || (cmpVec == 3'b010) || (cmpVec == 3'b001);
   end

   // Operand registers: each enabled pulse writes Y into its own nibble.
   // Nothing else ever touches a_op/b_op, so they only move on load edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_op <= '0;
         b_op <= '0;
      end else begin
         if (loadEn[0]) a_op[7:4] <= Y;
         if (loadEn[1]) a_op[3:0] <= Y;
         if (loadEn[2]) b_op[7:4] <= Y;
         if (loadEn[3]) b_op[3:0] <= Y;
      end
   end

   // Control FSM: LOAD accumulates the nibble mask, SETTLE gives the
   // comparator one cycle on the final operands and then captures, DONE
   // holds the result until any new press restarts loading.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= LOAD;
         loaded <= '0;
         l      <= 1'b0;
         g      <= 1'b0;
         eq     <= 1'b0;
         valid  <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               loaded <= loaded | pulse;
               if (loaded == 4'b1111) begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               l     <= cmp_l;
               g     <= cmp_g;
               eq    <= cmp_eq;
               err   <= ~cmpOneHot;
               valid <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               if (|pulse) begin
                  loaded <= pulse;
                  l      <= 1'b0;
                  g      <= 1'b0;
                  eq     <= 1'b0;
                  err    <= 1'b0;
                  valid  <= 1'b0;
                  state  <= LOAD;
               end
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eight_bit_comp_ctrl.sv
// tb_eight_bit_comp_ctrl
// Table-driven bench for eight_bit_comp_ctrl. Each table row presses one or
// more buttons with a Y value and comparator inputs; the expected outputs are
// queued when the press is driven and compared once the press has been
// released. Hand-written sequences cover cycle-accurate latency, presses
// during SETTLE, long holds, mid-sequence reset and hold-through-reset.

module tb_eight_bit_comp_ctrl;

   logic       clk;
   logic       reset_n;
   logic       PB1, PB2, PB3, PB4;
   logic [3:0] Y;
   logic       cmp_l, cmp_g, cmp_eq;
   logic [7:0] a_op, b_op;
   logic [3:0] loaded;
   logic       l, g, eq, valid, err;

   typedef struct {
      string      name;
      logic [3:0] pb;
      logic [3:0] y;
      logic [2:0] cmp;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] ld;
      logic [2:0] lge;
      logic       v;
      logic       e;
   } vecT;

   typedef struct {
      string       name;
      logic [24:0] vec;
   } expT;

   vecT vecs[$];
   expT sbQ[$];
   int  errors = 0;
   int  checks = 0;

   eight_bit_comp_ctrl #(.SYNC_STAGES(2)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .PB1    (PB1),
      .PB2    (PB2),
      .PB3    (PB3),
      .PB4    (PB4),
      .Y      (Y),
      .cmp_l  (cmp_l),
      .cmp_g  (cmp_g),
      .cmp_eq (cmp_eq),
      .a_op   (a_op),
      .b_op   (b_op),
      .loaded (loaded),
      .l      (l),
      .g      (g),
      .eq     (eq),
      .valid  (valid),
      .err    (err)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vecT mk(string name, logic [3:0] pb, logic [3:0] y, logic [2:0] cmp,
                              logic [7:0] a, logic [7:0] b, logic [3:0] ld,
                              logic [2:0] lge, logic v, logic e);
      vecT r;
      r.name = name; r.pb = pb; r.y = y; r.cmp = cmp;
      r.a = a; r.b = b; r.ld = ld; r.lge = lge; r.v = v; r.e = e;
      return r;
   endfunction

   function automatic logic [24:0] pack(logic [7:0] a, logic [7:0] b, logic [3:0] ld,
                                        logic [2:0] lge, logic v, logic e);
      return {a, b, ld, lge, v, e};
   endfunction

   function automatic logic [24:0] snap();
      return {a_op, b_op, loaded, l, g, eq, valid, err};
   endfunction

   function automatic string fmt(logic [24:0] s);
      return $sformatf("a=%h b=%h ld=%b lge=%b v=%b e=%b",
                       s[24:17], s[16:9], s[8:5], s[4:2], s[1], s[0]);
   endfunction

   // Compare one hand-computed value against the DUT
   task automatic checkField(input string name, input logic [24:0] act, input logic [24:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Pop the oldest scoreboard entry and compare the full output snapshot
   task automatic checkOutput();
      expT         e;
      logic [24:0] act;
      checks++;
      if (sbQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e   = sbQ.pop_front();
      act = snap();
      if (act !== e.vec) begin
         errors++;
         $display("[TB] FAIL %s: got %s, expected %s", e.name, fmt(act), fmt(e.vec));
      end
   endtask

   task automatic setPb(input logic [3:0] mask);
      {PB4, PB3, PB2, PB1} = mask;
   endtask

   // Raise buttons just after an edge; return just after the load edge
   task automatic drivePress(input logic [3:0] mask, input logic [3:0] yVal);
      @(posedge clk); #1;
      setPb(mask);
      Y = yVal;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic releaseAll();
      setPb(4'b0000);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Drive one table row and queue its expected outputs
   task automatic applyStimulus(input vecT v);
      expT e;
      {cmp_l, cmp_g, cmp_eq} = v.cmp;
      e.name = v.name;
      e.vec  = pack(v.a, v.b, v.ld, v.lge, v.v, v.e);
      sbQ.push_back(e);
      drivePress(v.pb, v.y);
      releaseAll();
      checkOutput();
   endtask

   // Main test sequence
   initial begin
      reset_n = 1'b1;
      setPb(4'b0000);
      Y = 4'h0;
      {cmp_l, cmp_g, cmp_eq} = 3'b000;

      // rows 0..17 run from the first reset, rows 18..23 after the mid-run reset
      vecs.push_back(mk("s1 pb1",        4'b0001, 4'h8, 3'b010, 8'h80, 8'h00, 4'b0001, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s1 pb2",        4'b0010, 4'hE, 3'b010, 8'h8E, 8'h00, 4'b0011, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s1 pb3",        4'b0100, 4'h2, 3'b010, 8'h8E, 8'h20, 4'b0111, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s1 pb4 g",      4'b1000, 4'hE, 3'b010, 8'h8E, 8'h2E, 4'b1111, 3'b010, 1'b1, 1'b0));
      vecs.push_back(mk("s5 done pb3",   4'b0100, 4'hF, 3'b010, 8'h8E, 8'hFE, 4'b0100, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("pb1 y0",        4'b0001, 4'h0, 3'b100, 8'h0E, 8'hFE, 4'b0101, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("pb2 y1",        4'b0010, 4'h1, 3'b100, 8'h01, 8'hFE, 4'b0111, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("pb4 l",         4'b1000, 4'h7, 3'b100, 8'h01, 8'hF7, 4'b1111, 3'b100, 1'b1, 1'b0));
      vecs.push_back(mk("s2 done pb4",   4'b1000, 4'h5, 3'b001, 8'h01, 8'hF5, 4'b1000, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s2 pb2",        4'b0010, 4'h5, 3'b001, 8'h05, 8'hF5, 4'b1010, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("repeat pb2",    4'b0010, 4'h9, 3'b001, 8'h09, 8'hF5, 4'b1010, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s2 pb3",        4'b0100, 4'h5, 3'b001, 8'h09, 8'h55, 4'b1110, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("repeat pb2 y5", 4'b0010, 4'h5, 3'b001, 8'h05, 8'h55, 4'b1110, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s2 pb1 eq",     4'b0001, 4'h5, 3'b001, 8'h55, 8'h55, 4'b1111, 3'b001, 1'b1, 1'b0));
      vecs.push_back(mk("s3 pb123",      4'b0111, 4'h3, 3'b001, 8'h33, 8'h35, 4'b0111, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s3 pb4",        4'b1000, 4'h3, 3'b001, 8'h33, 8'h33, 4'b1111, 3'b001, 1'b1, 1'b0));
      vecs.push_back(mk("err pb1",       4'b0001, 4'h1, 3'b110, 8'h13, 8'h33, 4'b0001, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("err pb234",     4'b1110, 4'h2, 3'b110, 8'h12, 8'h22, 4'b1111, 3'b110, 1'b1, 1'b1));
      vecs.push_back(mk("s6 pb1",        4'b0001, 4'hC, 3'b110, 8'hC0, 8'h00, 4'b0001, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s6 pb2",        4'b0010, 4'hD, 3'b110, 8'hCD, 8'h00, 4'b0011, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s6 pb3",        4'b0100, 4'h1, 3'b110, 8'hCD, 8'h10, 4'b0111, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("s6 pb4 err",    4'b1000, 4'h2, 3'b110, 8'hCD, 8'h12, 4'b1111, 3'b110, 1'b1, 1'b1));
      vecs.push_back(mk("none pb1",      4'b0001, 4'h0, 3'b000, 8'h0D, 8'h12, 4'b0001, 3'b000, 1'b0, 1'b0));
      vecs.push_back(mk("none pb234",    4'b1110, 4'h0, 3'b000, 8'h00, 8'h00, 4'b1111, 3'b000, 1'b1, 1'b1));

      // power-on reset
      #2 reset_n = 1'b0;
      #1 checkField("reset state", snap(), 25'd0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
      end

      // DONE holds its result even when the comparator inputs move
      {cmp_l, cmp_g, cmp_eq} = 3'b001;
      repeat (10) @(posedge clk);
      #1 checkField("done hold", snap(), pack(8'h12, 8'h22, 4'hF, 3'b110, 1'b1, 1'b1));

      // a press in DONE clears the result exactly on its load edge
      setPb(4'b0100);
      Y = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkField("done press pre-edge valid", {24'd0, valid}, 25'd1);
      @(posedge clk); #1;
      checkField("done press load edge", snap(), pack(8'h12, 8'hF2, 4'b0100, 3'b000, 1'b0, 1'b0));
      releaseAll();

      // fourth nibble to valid latency, with a press that lands in SETTLE
      applyStimulus(mk("lat pb12", 4'b0011, 4'h4, 3'b010, 8'h44, 8'hF2, 4'b0111, 3'b000, 1'b0, 1'b0));
      setPb(4'b1000);
      Y = 4'h6;
      {cmp_l, cmp_g, cmp_eq} = 3'b010;
      @(posedge clk); #1;
      checkField("lat edge k", {21'd0, loaded}, 25'b0111);
      @(posedge clk); #1;
      checkField("lat edge k+1", {21'd0, loaded}, 25'b0111);
      setPb(4'b1001);
      @(posedge clk); #1;
      checkField("lat edge k+2", snap(), pack(8'h44, 8'hF6, 4'hF, 3'b000, 1'b0, 1'b0));
      @(posedge clk); #1;
      checkField("lat settle valid", {24'd0, valid}, 25'd0);
      @(posedge clk); #1;
      checkField("lat capture", snap(), pack(8'h44, 8'hF6, 4'hF, 3'b010, 1'b1, 1'b0));
      releaseAll();
      checkField("settle press dropped", snap(), pack(8'h44, 8'hF6, 4'hF, 3'b010, 1'b1, 1'b0));

      // long hold of PB1 with Y changing every cycle loads once, Y at k+2
      setPb(4'b0001);
      for (int i = 0; i < 20; i++) begin
         Y = (i == 2) ? 4'hA : 4'(i + 3);
         @(posedge clk); #1;
      end
      releaseAll();
      checkField("long hold", snap(), pack(8'hA4, 8'hF6, 4'b0001, 3'b000, 1'b0, 1'b0));

      // partial sequence, then reset between edges with PB4 held
      applyStimulus(mk("part pb2", 4'b0010, 4'h7, 3'b010, 8'hA7, 8'hF6, 4'b0011, 3'b000, 1'b0, 1'b0));
      applyStimulus(mk("part pb3", 4'b0100, 4'h9, 3'b010, 8'hA7, 8'h96, 4'b0111, 3'b000, 1'b0, 1'b0));
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      setPb(4'b1000);
      #1 checkField("async reset", snap(), 25'd0);
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 checkField("held through reset", snap(), 25'd0);
      setPb(4'b0000);
      repeat (4) @(posedge clk);
      #1;

      for (int i = 18; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      checkField("scoreboard drained", {7'd0, 18'(sbQ.size())}, 25'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/eight_bit_comp_ctrl.md
EIGHT_BIT_COMP_CTRL -- requirements
Module: eight_bit_comp_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, reset_n.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops per push-button input; legal values are 2 or more.
REQ-003 Port clk, input, 1 bit: rising-edge system clock.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Ports PB1, PB2, PB3, PB4, input, 1 bit each: raw asynchronous push-buttons that load A[7:4], A[3:0], B[7:4] and B[3:0] respectively.
REQ-006 Port Y, input, 4 bits: nibble value from the switches, sampled at the load edge.
REQ-007 Ports cmp_l, cmp_g, cmp_eq, input, 1 bit each: combinational results from the comparator datapath (A<B, A>B, A==B).
REQ-008 Ports a_op and b_op, output, 8 bits each: registered operands driven to the comparator.
REQ-009 Port loaded, output, 4 bits: nibble-loaded mask, bit0=PB1 through bit3=PB4.
REQ-010 Ports l, g, eq, output, 1 bit each: registered comparison result.
REQ-011 Port valid, output, 1 bit: high while l, g and eq hold a result for the current a_op/b_op.
REQ-012 Port err, output, 1 bit: high when the captured comparator result was not one-hot.

Function
REQ-013 Each PBn SHALL pass through a SYNC_STAGES-flop synchronizer and then a one-flop rising-edge detector, giving one pulse per press regardless of hold time.
REQ-014 Load latency at default: PBn high before edge k; the nibble is written to a_op/b_op and loaded[n-1] is set at edge k+2.
REQ-015 FSM states SHALL be LOAD, SETTLE and DONE.
REQ-016 LOAD: each pulse writes Y to its nibble and sets its mask bit; simultaneous pulses SHALL all load in the same cycle.
REQ-017 LOAD: a repeat pulse for an already-loaded nibble SHALL overwrite that nibble; the mask is unchanged.
REQ-018 LOAD -> SETTLE SHALL occur on the edge after loaded becomes 4'b1111.
REQ-019 SETTLE: on the next edge, cmp_l/cmp_g/cmp_eq SHALL be captured into l/g/eq, valid set to 1, and the FSM SHALL go to DONE.
REQ-020 Fourth-nibble load to valid=1 SHALL be exactly 2 cycles.
REQ-021 SETTLE: button pulses SHALL be ignored and dropped.
REQ-022 Capture: err SHALL be set to 1 unless exactly one of cmp_l/cmp_g/cmp_eq is 1.
REQ-023 DONE: outputs SHALL hold indefinitely while no pulse occurs.
REQ-024 DONE: any pulse SHALL, on that edge, clear valid, l, g, eq and err; set loaded to only the pressed bit(s); write those nibble(s); and go to LOAD; all other operand nibbles retain their values.
REQ-025 a_op and b_op SHALL change only on load edges.

Reset
REQ-026 reset_n low SHALL immediately, without waiting for a clock edge, force state LOAD and clear a_op, b_op, loaded, l, g, eq, valid, err and all synchronizer and edge flops to 0.
REQ-027 Reset asserted mid-sequence SHALL discard partial loads; after release, a new sequence needs all four presses.
REQ-028 A button held through reset release SHALL NOT generate a pulse until it is released and pressed again.

Verification
REQ-029 Scenario 1: load Y=8,E,2,E via PB1..PB4 with cmp_g=1 -> a_op=0x8E, b_op=0x2E, and 2 cycles after the PB4 load: g=1, valid=1, err=0.
REQ-030 Scenario 2: press PB4, PB2, PB3, PB1 out of order with equal operands 0x55/0x55 and cmp_eq=1 -> eq=1, valid=1, loaded=4'b1111.
REQ-031 Scenario 3: press PB1, PB2 and PB3 in the same cycle with Y=3, then PB4 with Y=3 -> a_op=0x33, b_op=0x33, and valid follows 2 cycles after PB4.
REQ-032 Scenario 4: hold PB1 for 20 cycles with Y changing -> exactly one load, using the Y value at edge k+2.
REQ-033 Scenario 5: in DONE, press PB3 with Y=F -> valid=0 and loaded=4'b0100 on that edge; b_op[7:4]=F; a_op unchanged.
REQ-034 Scenario 6: assert reset_n low between clock edges after 3 loads -> all outputs 0 immediately; capture with cmp_l=cmp_g=1 in a later run -> err=1.
